// File: rtl/ualink_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ualink_port_arbiter
// Brief  : Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream
//          slave ports onto one master port, with per-port packet counters.
// Rev    : 1.0  initial release
// ============================================================================
module ualink_port_arbiter #(
   parameter int C_M_AXIS_DATA_WIDTH  = 64,
   parameter int C_S_AXIS_DATA_WIDTH  = 64,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_PORTS            = 5
) (
   input  logic                                      axi_aclk,
   input  logic                                      axi_resetn,
   input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
   output logic [NUM_PORTS-1:0]                      s_axis_tready,
   input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]          m_axis_tstrb,
   output logic                                      m_axis_tvalid,
   input  logic                                      m_axis_tready,
   output logic                                      m_axis_tlast,
   input  logic [NUM_PORTS-1:0]                      port_enable,
   output logic [2:0]                                cur_port,
   output logic                                      busy,
   input  logic [2:0]                                pkt_count_sel,
   output logic [31:0]                               pkt_count
);

   localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t              state_q;
   logic [2:0]          grant_q;
   logic [2:0]          last_grant_q;
   logic [31:0]         cnt_q [NUM_PORTS];

   logic [NUM_PORTS-1:0] w_cand;
   logic                 w_found;
   logic [2:0]           w_pick;
   int                   w_idx;
   logic                 w_done;

   // Round-robin search: first eligible port after the last winner, wrapping.
   always_comb begin
      w_cand  = s_axis_tvalid & port_enable;
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         w_idx = (int'(last_grant_q) + k) % NUM_PORTS;
         if (!w_found && w_cand[w_idx]) begin
            w_found = 1'b1;
            w_pick  = 3'(w_idx);
         end
      end
   end

   // Final beat of the granted packet: releases the grant and bumps its counter.
   assign w_done = (state_q == ST_XFER) && s_axis_tvalid[grant_q]
                   && m_axis_tready && s_axis_tlast[grant_q];

   // Zero-latency datapath: the granted slice passes straight through in XFER.
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tuser  = '0;
      m_axis_tstrb  = '0;
      s_axis_tready = '0;
      if (state_q == ST_XFER) begin
         m_axis_tvalid          = s_axis_tvalid[grant_q];
         m_axis_tlast           = s_axis_tlast[grant_q];
         m_axis_tdata           = s_axis_tdata[grant_q*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
         m_axis_tuser           = s_axis_tuser[grant_q*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
         m_axis_tstrb           = s_axis_tstrb[grant_q*STRB_W +: STRB_W];
         s_axis_tready[grant_q] = m_axis_tready;
      end
   end

   // Arbitration FSM; last_grant resets to the top port so port 0 wins first.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= 3'(NUM_PORTS - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_found) begin
                  grant_q <= w_pick;
                  state_q <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_done) begin
                  last_grant_q <= grant_q;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Per-port completed-packet counters, free-running with natural wrap.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
      end else if (w_done) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == 3'(p)) cnt_q[p] <= cnt_q[p] + 32'd1;
         end
      end
   end

   // Counter readback; selects beyond the populated ports read as zero.
   always_comb begin
      pkt_count = '0;
      if (int'(pkt_count_sel) < NUM_PORTS) pkt_count = cnt_q[pkt_count_sel];
   end

   assign cur_port = grant_q;
   assign busy     = (state_q == ST_XFER);

endmodule
`default_nettype wire

// File: tb/tb_ualink_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ualink_port_arbiter
// Brief  : Self-checking bench for ualink_port_arbiter: directed scenarios plus
//          a randomized phase, checked against a packet-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ualink_port_arbiter;

   localparam int P  = 5;
   localparam int DW = 64;
   localparam int UW = 128;
   localparam int SW = DW / 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [P*DW-1:0]   s_tdata = '0;
   logic [P*UW-1:0]   s_tuser = '0;
   logic [P*SW-1:0]   s_tstrb = '0;
   logic [P-1:0]      s_tvalid = '0;
   logic [P-1:0]      s_tready;
   logic [P-1:0]      s_tlast = '0;
   logic [DW-1:0]     m_tdata;
   logic [UW-1:0]     m_tuser;
   logic [SW-1:0]     m_tstrb;
   logic              m_tvalid;
   logic              m_tready = 1'b1;
   logic              m_tlast;
   logic [P-1:0]      en = '1;
   logic [2:0]        cur_port;
   logic              busy;
   logic [2:0]        sel = '0;
   logic [31:0]       pkt_count;

   ualink_port_arbiter #(
      .C_M_AXIS_DATA_WIDTH (DW),
      .C_S_AXIS_DATA_WIDTH (DW),
      .C_M_AXIS_TUSER_WIDTH(UW),
      .C_S_AXIS_TUSER_WIDTH(UW),
      .NUM_PORTS           (P)
   ) dut (
      .axi_aclk     (clk),
      .axi_resetn   (rst_n),
      .s_axis_tdata (s_tdata),
      .s_axis_tuser (s_tuser),
      .s_axis_tstrb (s_tstrb),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tlast (s_tlast),
      .m_axis_tdata (m_tdata),
      .m_axis_tuser (m_tuser),
      .m_axis_tstrb (m_tstrb),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tlast (m_tlast),
      .port_enable  (en),
      .cur_port     (cur_port),
      .busy         (busy),
      .pkt_count_sel(sel),
      .pkt_count    (pkt_count)
   );

   always #5 clk = ~clk;

   // Source-side packet state per port
   int          plen [P];
   int          pidx [P];
   int          pseq [P];
   bit          want [P];
   bit          drop [P];
   bit          auto_next [P];
   int          fixed_len;
   bit          rnd_drop;
   bit          rnd_ready;

   // Reference model: who owns the master port, who won last, packets per port
   bit          exp_busy;
   int          exp_grant;
   int          exp_last;
   int unsigned cnt [P];
   int          grant_log [$];
   int          busy_cycles;

   int          vectors;
   int          miscompares;

   function automatic logic [63:0] payload(int p, int seq, int idx);
      return {8'(p), 24'(seq), 32'(idx)} ^ 64'h5A5A_0000_C3C3_0000;
   endfunction

   function automatic int new_len();
      return (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 6));
   endfunction

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int p = 0; p < P; p++) begin
         logic [63:0] d;
         d = payload(p, pseq[p], pidx[p]);
         s_tdata[p*DW +: DW] = d;
         s_tuser[p*UW +: UW] = {~d, d};
         s_tstrb[p*SW +: SW] = d[7:0] ^ 8'hA5;
         s_tvalid[p]         = want[p] && !drop[p];
         s_tlast[p]          = (pidx[p] == plen[p] - 1);
      end
   endtask

   // One clock: check outputs mid-cycle, then advance model and sources.
   task automatic step();
      logic [63:0]  d;
      logic [P-1:0] tr;
      bit           hs;
      int           win;
      int           g;
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
      if (exp_busy) begin
         d  = payload(exp_grant, pseq[exp_grant], pidx[exp_grant]);
         tr = '0;
         tr[exp_grant] = m_tready;
         chk("m_tvalid", 256'(m_tvalid), 256'(want[exp_grant] && !drop[exp_grant]));
         chk("m_tdata",  256'(m_tdata),  256'(d));
         chk("m_tuser",  256'(m_tuser),  256'({~d, d}));
         chk("m_tstrb",  256'(m_tstrb),  256'(d[7:0] ^ 8'hA5));
         chk("m_tlast",  256'(m_tlast),  256'(pidx[exp_grant] == plen[exp_grant] - 1));
         chk("s_tready", 256'(s_tready), 256'(tr));
      end else begin
         chk("idle_out", 256'({m_tvalid, m_tlast, m_tstrb, m_tdata, m_tuser}), '0);
         chk("idle_tready", 256'(s_tready), '0);
      end
      chk("busy", 256'(busy), 256'(exp_busy));
      chk("cur_port", 256'(cur_port), 256'(exp_grant));
      chk("pkt_count", 256'(pkt_count), (int'(sel) < P) ? 256'(cnt[sel]) : '0);

      hs  = exp_busy && want[exp_grant] && !drop[exp_grant] && m_tready;
      win = -1;
      if (!exp_busy) begin
         for (int k = 1; k <= P; k++) begin
            int q;
            q = (exp_last + k) % P;
            if (win < 0 && want[q] && !drop[q] && en[q]) win = q;
         end
      end

      @(posedge clk);
      #1;
      if (hs) begin
         g = exp_grant;
         if (pidx[g] == plen[g] - 1) begin
            cnt[g]++;
            exp_busy = 0;
            exp_last = g;
            pseq[g]++;
            pidx[g]  = 0;
            plen[g]  = new_len();
            want[g]  = auto_next[g];
         end else begin
            pidx[g]++;
         end
      end else if (win >= 0) begin
         exp_busy  = 1;
         exp_grant = win;
         grant_log.push_back(win);
      end
      if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
      for (int p = 0; p < P; p++) drop[p] = rnd_drop && ($urandom_range(0, 3) == 0);
      sel = 3'($urandom_range(0, 7));
      drive_inputs();
   endtask

   // Async reset: outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      #1 rst_n = 1'b0;
      #1;
      exp_busy  = 0;
      exp_last  = P - 1;
      exp_grant = 0;
      for (int p = 0; p < P; p++) begin
         cnt[p]  = 0;
         pidx[p] = 0;
      end
      sel = 3'd4;
      #1;
      chk("rst_out", 256'({m_tvalid, m_tlast, m_tstrb, m_tdata, m_tuser}), '0);
      chk("rst_tready", 256'(s_tready), '0);
      chk("rst_busy", 256'(busy), '0);
      chk("rst_cur_port", 256'(cur_port), '0);
      chk("rst_pkt_count4", 256'(pkt_count), '0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive_inputs();
   endtask

   task automatic clear_sources();
      for (int p = 0; p < P; p++) begin
         want[p] = 0; drop[p] = 0; auto_next[p] = 0; plen[p] = 1; pidx[p] = 0;
      end
      rnd_drop = 0; rnd_ready = 0; m_tready = 1'b1; en = '1; fixed_len = 0;
   endtask

   task automatic chk_cnt(string tag, int p, int unsigned exp);
      sel = 3'(p);
      #1;
      chk(tag, 256'(pkt_count), 256'(exp));
   endtask

   task automatic wait_pkts(int p, int unsigned n, int budget);
      for (int i = 0; i < budget && cnt[p] < n; i++) step();
   endtask

   initial begin
      int rr_exp [6];
      rr_exp = '{0, 1, 2, 3, 4, 0};
      vectors = 0; miscompares = 0;
      for (int p = 0; p < P; p++) pseq[p] = 0;
      clear_sources();
      do_reset();

      // Single 14-beat packet on port 0
      busy_cycles = 0;
      want[0] = 1; plen[0] = 14;
      drive_inputs();
      for (int i = 0; i < 17; i++) step();
      chk("p0_busy_cycles", 256'(busy_cycles), 256'(14));
      chk_cnt("p0_count", 0, 1);

      // Five ports contending with 3-beat packets: strict rotation
      clear_sources();
      do_reset();
      grant_log.delete();
      fixed_len = 3;
      for (int p = 0; p < P; p++) begin
         want[p] = 1; auto_next[p] = 1; plen[p] = 3;
      end
      drive_inputs();
      for (int i = 0; i < 25; i++) step();
      for (int i = 0; i < 6; i++)
         chk($sformatf("rr_order%0d", i),
             256'((i < grant_log.size()) ? grant_log[i] : -1), 256'(rr_exp[i]));

      // Backpressure on a 24-beat packet from port 3
      clear_sources();
      do_reset();
      want[3] = 1; plen[3] = 24; rnd_ready = 1;
      drive_inputs();
      wait_pkts(3, 1, 400);
      rnd_ready = 0; m_tready = 1'b1;
      chk_cnt("p3_count", 3, 1);

      // port_enable masking, and disabling the owner mid-packet
      clear_sources();
      do_reset();
      en = 5'b11101;
      want[1] = 1; plen[1] = 4;
      want[2] = 1; plen[2] = 4;
      drive_inputs();
      step();
      step();
      chk("en_skip_grant", 256'(cur_port), 256'(2));
      en[2] = 1'b0;
      wait_pkts(2, 1, 20);
      chk_cnt("p2_count", 2, 1);
      for (int i = 0; i < 3; i++) step();
      chk_cnt("p1_count", 1, 0);

      // Reset in the middle of a port-4 packet
      clear_sources();
      do_reset();
      want[4] = 1; plen[4] = 10;
      drive_inputs();
      for (int i = 0; i < 20 && pidx[4] < 5; i++) step();
      want[2] = 1; plen[2] = 2;
      drive_inputs();
      do_reset();
      step();
      step();
      chk("rst_regrant", 256'(cur_port), 256'(2));

      // Randomized traffic with drops, backpressure and enable churn
      clear_sources();
      do_reset();
      for (int p = 0; p < P; p++) begin
         want[p] = 1; auto_next[p] = 1; plen[p] = new_len();
      end
      rnd_drop = 1; rnd_ready = 1;
      drive_inputs();
      for (int i = 0; i < 1500; i++) begin
         if (i % 16 == 0) en = P'($urandom_range(0, (1 << P) - 1));
         step();
      end
      for (int p = 0; p < 8; p++)
         chk_cnt($sformatf("final_count%0d", p), p, (p < P) ? cnt[p] : 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
